// File: rtl/pure_fpga_pkg.sv
// Shared definitions for the instruction prefetch path: word width, NOP
// encoding and the prefetch FSM state type.
package pure_fpga_pkg;

  localparam int WIDTH = 16;

  localparam logic [WIDTH-1:0] NOP = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } prefetch_state_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch buffer: synchronous FIFO of (word, pc) pairs with push, pop,
// flush and occupancy. The head outputs read only from storage registers.
module prefetch_fifo
  import pure_fpga_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic [WIDTH-1:0]       push_pc,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] level,
  output logic                   head_valid,
  output logic [WIDTH-1:0]       head_data,
  output logic [WIDTH-1:0]       head_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem   [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && (level != LW'(DEPTH));
  assign pop_ok  = pop && (level != '0);

  // Flush dominates: a same-cycle push or pop is discarded with the contents.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok && !flush) begin
      data_mem[wr_ptr] <= push_data;
      pc_mem[wr_ptr]   <= push_pc;
    end
  end

  assign head_valid = (level != '0);
  assign head_data  = head_valid ? data_mem[rd_ptr] : WIDTH'(NOP);
  assign head_pc    = head_valid ? pc_mem[rd_ptr] : '0;

endmodule

// File: rtl/instruction_prefetch.sv
// Instruction prefetcher: issues ROM fetches ahead of the consumer and
// handles redirects. Optional flush counter under PREFETCH_FLUSH_STATS_EN.
module instruction_prefetch
  import pure_fpga_pkg::*;
#(
  parameter int WIDTH = pure_fpga_pkg::WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  output logic [WIDTH-1:0]       rom_address,
  input  logic [WIDTH-1:0]       rom_data,
  input  logic                   redirect_valid,
  input  logic [WIDTH-1:0]       redirect_address,
  output logic                   instr_valid,
  output logic [WIDTH-1:0]       instr_data,
  output logic [WIDTH-1:0]       instr_pc,
  input  logic                   instr_ready,
  output logic [$clog2(DEPTH):0] level,
`ifdef PREFETCH_FLUSH_STATS_EN
  output logic [WIDTH-1:0]       flush_count,
`endif
  output prefetch_state_t        fsm_state
);

  localparam int LW = $clog2(DEPTH) + 1;

  prefetch_state_t  state;
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] inflight_pc;
  logic             inflight_valid;
  logic             inflight_epoch;
  logic             epoch;
  logic             redirect_accept;
  logic             issue;
  logic             push;
  logic             pop;
  logic [LW:0]      occupancy;

  assign redirect_accept = redirect_valid && (state != ST_IDLE);
  assign occupancy       = {1'b0, level} + (LW+1)'(inflight_valid);
  assign issue           = (state == ST_RUN) && !redirect_valid &&
                           (occupancy < (LW+1)'(DEPTH));
  // Responses from a fetch issued before the latest redirect carry a stale epoch.
  assign push            = inflight_valid && (inflight_epoch == epoch);
  // Handshake: the head transfers in a cycle where instr_valid and instr_ready
  // are both high; instr_valid never depends on instr_ready. A redirect in the
  // same cycle discards the head instead of transferring it.
  assign pop             = instr_valid && instr_ready;
  assign rom_address     = fetch_pc;
  assign fsm_state       = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      fetch_pc       <= '0;
      epoch          <= 1'b0;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
      inflight_epoch <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:  state <= ST_RUN;
        ST_RUN:   state <= redirect_valid ? ST_FLUSH : ST_RUN;
        ST_FLUSH: state <= redirect_valid ? ST_FLUSH : ST_RUN;
        default:  state <= ST_IDLE;
      endcase
      if (redirect_accept) begin
        fetch_pc <= redirect_address;
        epoch    <= ~epoch;
      end else if (issue) begin
        fetch_pc <= fetch_pc + WIDTH'(1);
      end
      inflight_valid <= issue;
      if (issue) begin
        inflight_pc    <= fetch_pc;
        inflight_epoch <= epoch;
      end
    end
  end

`ifdef PREFETCH_FLUSH_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flush_count <= '0;
    end else if (redirect_accept && (flush_count != '1)) begin
      flush_count <= flush_count + WIDTH'(1);
    end
  end
`endif

  prefetch_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push),
    .push_data  (rom_data),
    .push_pc    (inflight_pc),
    .pop        (pop),
    .flush      (redirect_accept),
    .level      (level),
    .head_valid (instr_valid),
    .head_data  (instr_data),
    .head_pc    (instr_pc)
  );

endmodule

// File: tb/tb_instruction_prefetch.sv
// Bench for instruction_prefetch: ROM model, expected-stream scoreboard,
// directed redirect/reset scenarios.
module tb_instruction_prefetch;
  import pure_fpga_pkg::*;

  localparam int W = 16;
  localparam int D = 4;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic [W-1:0]         rom_address;
  logic [W-1:0]         rom_data = '0;
  logic                 redirect_valid;
  logic [W-1:0]         redirect_address;
  logic                 instr_valid;
  logic [W-1:0]         instr_data;
  logic [W-1:0]         instr_pc;
  logic                 instr_ready;
  logic [$clog2(D):0]   level;
  prefetch_state_t      fsm_state;
`ifdef PREFETCH_FLUSH_STATS_EN
  logic [W-1:0]         flush_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_emit   = 0;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   exp_tail;
  logic [2*W-1:0] mon_word;

  instruction_prefetch #(.WIDTH(W), .DEPTH(D)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .rom_address      (rom_address),
    .rom_data         (rom_data),
    .redirect_valid   (redirect_valid),
    .redirect_address (redirect_address),
    .instr_valid      (instr_valid),
    .instr_data       (instr_data),
    .instr_pc         (instr_pc),
    .instr_ready      (instr_ready),
    .level            (level),
`ifdef PREFETCH_FLUSH_STATS_EN
    .flush_count      (flush_count),
`endif
    .fsm_state        (fsm_state)
  );

  // clock / reset-independent infrastructure
  always #5 clock = ~clock;

  always @(posedge clock) rom_data <= W'(16'hA000 + rom_address);

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_push_one();
    exp_q.push_back({exp_tail, W'(16'hA000 + exp_tail)});
    exp_tail = exp_tail + 1'b1;
  endtask

  task automatic sb_restart(input logic [W-1:0] start);
    exp_q.delete();
    exp_tail = start;
    repeat (8) sb_push_one();
  endtask

  task automatic wait_emit(input string tag, input logic [W-1:0] exp_pc);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(instr_valid && instr_ready) && n < 30);
    check(tag, 32'({instr_valid, instr_pc}), 32'({1'b1, exp_pc}));
    check({tag, "_data"}, 32'(instr_data), 32'(W'(16'hA000 + exp_pc)));
  endtask

  // scoreboard: every accepted head must be the next word of the expected stream
  always @(negedge clock) begin
    if (reset_n && instr_valid && instr_ready && !redirect_valid) begin
      n_emit++;
      mon_word = exp_q.pop_front();
      check("sb_pc", 32'(instr_pc), 32'(mon_word[2*W-1:W]));
      check("sb_data", 32'(instr_data), 32'(mon_word[W-1:0]));
      while (exp_q.size() < 8) sb_push_one();
    end
  end

  initial begin
    int n;
    redirect_valid   = 1'b0;
    redirect_address = '0;
    instr_ready      = 1'b1;
    sb_restart('0);

    // reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_rom_address", 32'(rom_address), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr_data", 32'(instr_data), 32'd0);
    check("rst_instr_pc", 32'(instr_pc), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
`ifdef PREFETCH_FLUSH_STATS_EN
    check("rst_flush_count", 32'(flush_count), 32'd0);
`endif

    // boot: first word three edges after release, then back to back
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    check("boot_idle", 32'(fsm_state), 32'(ST_IDLE));
    @(negedge clock);
    check("boot_run", 32'(fsm_state), 32'(ST_RUN));
    check("boot_valid_e0", 32'(instr_valid), 32'd0);
    @(negedge clock);
    check("boot_valid_e1", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("boot_seq", 32'({instr_valid, instr_pc}), 32'({1'b1, W'(i)}));
      check("boot_seq_data", 32'(instr_data), 32'(W'(16'hA000 + i)));
    end
    repeat (6) @(negedge clock);

    // back-pressure from reset: buffer fills, fetch stops at 4
    @(posedge clock); #1 reset_n = 1'b0; instr_ready = 1'b0; sb_restart('0);
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (8) @(negedge clock);
    check("hold_rom_address_a", 32'(rom_address), 32'd4);
    repeat (4) @(negedge clock);
    check("hold_level_full", 32'(level), 32'd4);
    check("hold_rom_address_b", 32'(rom_address), 32'd4);
    check("hold_head_pc", 32'({instr_valid, instr_pc}), 32'({1'b1, 16'h0000}));
    @(posedge clock); #1 instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) wait_emit("hold_resume", W'(i));

    // redirect with level 3 and one fetch in flight
    @(posedge clock); #1 instr_ready = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (level != 3 && n < 20);
    check("rd1_level3", 32'(level), 32'd3);
    redirect_valid = 1'b1; redirect_address = 16'h0040; sb_restart(16'h0040);
    @(posedge clock); #1 redirect_valid = 1'b0;
    @(negedge clock);
    check("rd1_level0", 32'(level), 32'd0);
    check("rd1_state_flush", 32'(fsm_state), 32'(ST_FLUSH));
    instr_ready = 1'b1;
    wait_emit("rd1_first", 16'h0040);

    // back-to-back redirects: the second one wins
    repeat (4) @(negedge clock);
    @(posedge clock); #1 redirect_valid = 1'b1; redirect_address = 16'h0010; sb_restart(16'h0010);
    @(posedge clock); #1 redirect_address = 16'h0020; sb_restart(16'h0020);
    @(negedge clock);
    check("rd2_state_flush", 32'(fsm_state), 32'(ST_FLUSH));
    @(posedge clock); #1 redirect_valid = 1'b0;
    @(negedge clock);
    check("rd2_flush_restart", 32'(fsm_state), 32'(ST_FLUSH));
    @(negedge clock);
    check("rd2_state_run", 32'(fsm_state), 32'(ST_RUN));
    wait_emit("rd2_first", 16'h0020);
    wait_emit("rd2_second", 16'h0021);
`ifdef PREFETCH_FLUSH_STATS_EN
    check("stats_three", 32'(flush_count), 32'd3);
`endif

    // reset mid-stream with two buffered words
    repeat (4) @(negedge clock);
    @(posedge clock); #1 instr_ready = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (level != 2 && n < 20);
    check("mid_level2", 32'(level), 32'd2);
    reset_n = 1'b0;
    #1;
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_data", 32'(instr_data), 32'd0);
    check("mid_rst_pc", 32'(instr_pc), 32'd0);
    check("mid_rst_rom_address", 32'(rom_address), 32'd0);
    check("mid_rst_state", 32'(fsm_state), 32'(ST_IDLE));
`ifdef PREFETCH_FLUSH_STATS_EN
    check("mid_rst_flush_count", 32'(flush_count), 32'd0);
`endif
    sb_restart('0);
    @(posedge clock); #1 reset_n = 1'b1; instr_ready = 1'b1;
    wait_emit("mid_restart_0", 16'h0000);
    wait_emit("mid_restart_1", 16'h0001);

    // pc wrap
    repeat (3) @(negedge clock);
    @(posedge clock); #1 redirect_valid = 1'b1; redirect_address = 16'hFFFE; sb_restart(16'hFFFE);
    @(posedge clock); #1 redirect_valid = 1'b0;
    wait_emit("wrap_fffe", 16'hFFFE);
    wait_emit("wrap_ffff", 16'hFFFF);
    wait_emit("wrap_0000", 16'h0000);
    repeat (20) @(negedge clock);
    check("emit_count", 32'(n_emit >= 30), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
